// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned INST_W = 32;

   localparam logic [XLEN-1:0]   PC_STEP  = XLEN'(4);
   localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [INST_W-1:0] instr;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return pc & ~(XLEN'(3));
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry FIFO of fetched {pc, instr} pairs; flush beats push/pop.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic         i_flush,
   input  fetch_entry_t i_wdata,
   output logic [CW-1:0] o_count,
   output logic         o_empty,
   output logic         o_full,
   output fetch_entry_t o_head
);

   localparam int unsigned AW = $clog2(DEPTH);

   fetch_entry_t  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_count   = r_count;
   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CW'(DEPTH));
   assign o_head    = r_mem[r_rptr];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   // Storage is cleared on reset so the head reads as zero until the first push.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_mem[i] <= '0;
         end
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wptr] <= i_wdata;
            r_wptr        <= r_wptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + CW'(1);
         end else if (w_do_pop && !w_do_push) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: sequential PC generation, credit-limited imem requests, response
// buffering, and redirect handling that discards stale in-flight responses.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_redirect_valid,
   input  logic [XLEN-1:0]   i_redirect_pc,
   output logic              o_imem_req_valid,
   input  logic              i_imem_req_ready,
   output logic [XLEN-1:0]   o_imem_req_addr,
   input  logic              i_imem_rsp_valid,
   input  logic [INST_W-1:0] i_imem_rsp_data,
   output logic              o_inst_valid,
   input  logic              i_inst_ready,
   output logic [INST_W-1:0] o_inst_data,
   output logic [XLEN-1:0]   o_inst_pc
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [XLEN-1:0] r_fetch_pc;
   logic [XLEN-1:0] r_resp_pc;
   logic [CW-1:0]   r_outstanding;
   logic [CW-1:0]   r_drop_cnt;

   logic [CW-1:0]   w_fifo_count;
   logic            w_fifo_empty;
   logic            w_fifo_full;
   fetch_entry_t    w_head;
   fetch_entry_t    w_wdata;
   logic [CW:0]     w_inflight;
   logic            w_req_fire;
   logic            w_rsp_keep;
   logic            w_push;
   logic            w_pop;

   // Buffered plus in-flight words never exceed DEPTH, so every response has a slot.
   assign w_inflight       = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
   assign o_imem_req_valid = (w_inflight < (CW + 1)'(DEPTH)) && !i_redirect_valid;
   assign o_imem_req_addr  = r_fetch_pc;
   assign w_req_fire       = o_imem_req_valid && i_imem_req_ready;

   assign w_rsp_keep   = i_imem_rsp_valid && (r_drop_cnt == '0) && !i_redirect_valid;
   assign w_push       = w_rsp_keep && !w_fifo_full;
   assign o_inst_valid = !w_fifo_empty && !i_redirect_valid;
   assign w_pop        = o_inst_valid && i_inst_ready;
   assign o_inst_data  = w_head.instr;
   assign o_inst_pc    = w_head.pc;

   always_comb begin
      w_wdata       = '0;
      w_wdata.pc    = r_resp_pc;
      w_wdata.instr = i_imem_rsp_data;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_fetch_pc    <= RESET_PC;
         r_resp_pc     <= RESET_PC;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
      end else if (i_redirect_valid) begin
         // Everything still in flight after this cycle belongs to the old stream.
         r_fetch_pc    <= align_pc(i_redirect_pc);
         r_resp_pc     <= align_pc(i_redirect_pc);
         r_outstanding <= r_outstanding - CW'(i_imem_rsp_valid);
         r_drop_cnt    <= r_outstanding - CW'(i_imem_rsp_valid);
      end else begin
         if (w_req_fire) begin
            r_fetch_pc <= r_fetch_pc + PC_STEP;
         end
         r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(i_imem_rsp_valid);
         if (i_imem_rsp_valid) begin
            if (r_drop_cnt != '0) begin
               r_drop_cnt <= r_drop_cnt - CW'(1);
            end else begin
               r_resp_pc <= r_resp_pc + PC_STEP;
            end
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (i_redirect_valid),
      .i_wdata (w_wdata),
      .o_count (w_fifo_count),
      .o_empty (w_fifo_empty),
      .o_full  (w_fifo_full),
      .o_head  (w_head)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with an in-order, fixed-latency memory model.
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;

   int total = 0;
   int bad = 0;

   fetch_unit #(
      .DEPTH    (DEPTH),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .i_clk            (clk),
      .i_reset          (reset),
      .i_redirect_valid (redirect_valid),
      .i_redirect_pc    (redirect_pc),
      .o_imem_req_valid (imem_req_valid),
      .i_imem_req_ready (imem_req_ready),
      .o_imem_req_addr  (imem_req_addr),
      .i_imem_rsp_valid (imem_rsp_valid),
      .i_imem_rsp_data  (imem_rsp_data),
      .o_inst_valid     (inst_valid),
      .i_inst_ready     (inst_ready),
      .o_inst_data      (inst_data),
      .o_inst_pc        (inst_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // Memory model: in-order, fixed latency, shares the reset
   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   pend_t       pend[$];
   int          cyc = 0;
   int          lat = 1;
   int          n_acc = 0;
   logic [31:0] acc_addr [0:1023];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         pend.delete();
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
      end else begin
         if (imem_rsp_valid) void'(pend.pop_front());
         if (imem_req_valid && imem_req_ready) begin
            pend.push_back('{addr: imem_req_addr, due: cyc + lat});
            if (n_acc < 1024) acc_addr[n_acc] = imem_req_addr;
            n_acc++;
         end
         cyc++;
         #1;
         if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend[0].addr);
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
         end
      end
   end

   always @(posedge clk) begin
      if (!reset) begin
         assert (!(dut.w_rsp_keep && dut.w_fifo_full))
            else $error("FAIL assert_push_full: push while FIFO full");
         assert (!(imem_rsp_valid && dut.r_outstanding == '0))
            else $error("FAIL assert_rsp_no_outstanding: response with nothing outstanding");
      end
   end

   // Scoreboard
   fetch_entry_t exp_q[$];
   logic [31:0]  next_pc = '0;

   task automatic push_exp(input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back('{pc: next_pc, instr: mem_word(next_pc)});
         next_pc = next_pc + 32'd4;
      end
   endtask

   // One cycle: compare any instruction consumed at the coming edge, end at edge+1.
   task automatic step();
      fetch_entry_t e;
      @(negedge clk);
      if (!reset && inst_valid && inst_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_extra: got pc=%h data=%h, none expected", inst_pc, inst_data);
         end else begin
            e = exp_q.pop_front();
            if (inst_pc !== e.pc || inst_data !== e.instr) begin
               bad++;
               $display("FAIL sb_inst: got pc=%h data=%h, want pc=%h data=%h",
                        inst_pc, inst_data, e.pc, e.instr);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int budget, output int cycles);
      inst_ready = 1'b1;
      cycles = 0;
      while (exp_q.size() != 0 && cycles < budget) begin
         step();
         cycles++;
      end
      inst_ready = 1'b0;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain_timeout: %0d still expected after %0d cycles", exp_q.size(), cycles);
         exp_q.delete();
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      redirect_valid = 1'b0;
      inst_ready = 1'b0;
      imem_req_ready = 1'b1;
      exp_q.delete();
      next_pc = '0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      total += 3;
      if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", inst_valid); end
      if (inst_data !== 32'h0) begin bad++; $display("FAIL rst_data: got %h want 0", inst_data); end
      if (inst_pc !== 32'h0) begin bad++; $display("FAIL rst_pc: got %h want 0", inst_pc); end
      reset = 1'b0;
      #1;
      total += 2;
      if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL rst_req_valid: got %b want 1", imem_req_valid); end
      if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL rst_req_addr: got %h want 0", imem_req_addr); end
      for (int i = 0; i < 6; i++) step();
      next_pc = '0;
   endtask

   task automatic test_stream();
      int cycles;
      push_exp(8);
      drain(40, cycles);
      total++;
      if (cycles !== 8) begin bad++; $display("FAIL stream_rate: got %0d cycles want 8", cycles); end
   endtask

   task automatic test_backpressure();
      int start;
      int cycles;
      do_reset();
      start = n_acc;
      for (int i = 0; i < 10; i++) step();
      total += 2;
      if (n_acc - start !== 4) begin bad++; $display("FAIL bp_count: got %0d want 4", n_acc - start); end
      if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL bp_req_valid: got %b want 0", imem_req_valid); end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (acc_addr[start + i] !== 32'(i * 4)) begin
            bad++;
            $display("FAIL bp_addr%0d: got %h want %h", i, acc_addr[start + i], 32'(i * 4));
         end
      end
      push_exp(6);
      drain(40, cycles);
      total++;
      if (acc_addr[start + 4] !== 32'h10) begin
         bad++;
         $display("FAIL bp_resume: got %h want 00000010", acc_addr[start + 4]);
      end
   endtask

   task automatic test_mem_stall();
      int start;
      int cycles;
      bit found = 1'b0;
      do_reset();
      start = n_acc;
      for (int i = 0; i < 10 && !found; i++) begin
         if (imem_req_valid && imem_req_addr == 32'h8) found = 1'b1;
         else step();
      end
      total++;
      if (!found) begin bad++; $display("FAIL stall_reach: got addr %h want 00000008", imem_req_addr); end
      imem_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         total += 2;
         if (imem_req_addr !== 32'h8) begin bad++; $display("FAIL stall_addr: got %h want 00000008", imem_req_addr); end
         if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL stall_valid: got %b want 1", imem_req_valid); end
      end
      total++;
      if (n_acc - start !== 2) begin bad++; $display("FAIL stall_acc: got %0d want 2", n_acc - start); end
      imem_req_ready = 1'b1;
      push_exp(6);
      drain(40, cycles);
      total += 2;
      if (acc_addr[start + 2] !== 32'h8) begin bad++; $display("FAIL stall_resume8: got %h want 00000008", acc_addr[start + 2]); end
      if (acc_addr[start + 3] !== 32'hC) begin bad++; $display("FAIL stall_resumeC: got %h want 0000000c", acc_addr[start + 3]); end
   endtask

   task automatic test_redirect();
      int start;
      int cycles;
      lat = 2;
      do_reset();
      step();
      step();
      // Two requests outstanding, the first response is on the bus now.
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0103;
      start = n_acc;
      #1;
      total += 2;
      if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL redir_req: got %b want 0", imem_req_valid); end
      if (inst_valid !== 1'b0) begin bad++; $display("FAIL redir_inst: got %b want 0", inst_valid); end
      step();
      redirect_valid = 1'b0;
      next_pc = 32'h100;
      push_exp(4);
      drain(40, cycles);
      total++;
      if (acc_addr[start] !== 32'h100) begin bad++; $display("FAIL redir_target: got %h want 00000100", acc_addr[start]); end
   endtask

   task automatic test_flush();
      int cycles;
      lat = 1;
      do_reset();
      for (int i = 0; i < 6; i++) step();
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0042;
      inst_ready = 1'b1;
      #1;
      total++;
      if (inst_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", inst_valid); end
      step();
      redirect_valid = 1'b0;
      inst_ready = 1'b0;
      next_pc = 32'h40;
      push_exp(4);
      drain(40, cycles);
   endtask

   task automatic test_back_to_back();
      int cycles;
      lat = 3;
      do_reset();
      for (int i = 0; i < 3; i++) step();
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0200;
      step();
      redirect_pc = 32'h0000_0300;
      step();
      redirect_valid = 1'b0;
      next_pc = 32'h300;
      push_exp(5);
      drain(60, cycles);
   endtask

   task automatic test_async_reset();
      int cycles;
      lat = 1;
      do_reset();
      for (int i = 0; i < 4; i++) step();
      @(negedge clk);
      total += 2;
      if (inst_valid !== 1'b1) begin bad++; $display("FAIL ar_pre_valid: got %b want 1", inst_valid); end
      if (inst_pc !== 32'h0) begin bad++; $display("FAIL ar_pre_pc: got %h want 0", inst_pc); end
      #1;
      reset = 1'b1;
      #1;
      total += 3;
      if (inst_valid !== 1'b0) begin bad++; $display("FAIL ar_valid: got %b want 0", inst_valid); end
      if (inst_data !== 32'h0) begin bad++; $display("FAIL ar_data: got %h want 0", inst_data); end
      if (inst_pc !== 32'h0) begin bad++; $display("FAIL ar_pc: got %h want 0", inst_pc); end
      @(posedge clk);
      #1;
      step();
      reset = 1'b0;
      exp_q.delete();
      next_pc = '0;
      #1;
      total++;
      if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL ar_req_addr: got %h want 0", imem_req_addr); end
      push_exp(3);
      drain(40, cycles);
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_mem_stall();
      test_redirect();
      test_flush();
      test_back_to_back();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
